wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Two-master to one-slave arbiter for the core's 16-bit Wishbone B.4 master port.
- Shares the external bus between the instruction-fetch unit (I-master) and the load/store unit (D-master).
- Requesters ask for the bus with req; the arbiter answers with a registered grant. A master drives cyc/stb only while granted.
- Holds the grant for a whole bus transaction, which may be a multi-beat word or dword sequence. Routes ack and read data back to the owner only.

Parameters:
- AW, 64, address width
- DW, 16, data width
- SW, 2, select width (DW/8)

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- ireq_i  in  1  I-master bus request; held until its transaction completes
- igrant_o  out  1  I-master owns bus
- iadr_i  in  AW  I-master address
- idat_i  in  DW  I-master write data
- iwe_i  in  1  I-master write enable
- istb_i  in  1  I-master strobe
- icyc_i  in  1  I-master cycle
- isel_i  in  SW  I-master byte selects
- iack_o  out  1  ack to I-master
- idat_o  out  DW  read data to I-master
- dreq_i, dgrant_o, dadr_i, ddat_i, dwe_i, dstb_i, dcyc_i, dsel_i, dack_o, ddat_o  same as I-master, for the D-master
- wbmadr_o  out  AW  bus address
- wbmdat_o  out  DW  bus write data
- wbmwe_o  out  1  bus write enable
- wbmstb_o  out  1  bus strobe
- wbmcyc_o  out  1  bus cycle
- wbmsel_o  out  SW  bus selects
- wbmack_i  in  1  bus ack
- wbmdat_i  in  DW  bus read data

Behaviour:
- States: IDLE, OWN_I, OWN_D. igrant_o=(state==OWN_I), dgrant_o=(state==OWN_D); both are registered.
- Reset (reset_i high at clock edge): state->IDLE. All outputs 0 during and after reset. Any transaction in flight is abandoned; wbmcyc_o drops in the cycle after the reset edge.
- IDLE:
  - dreq_i -> OWN_D.
  - else ireq_i -> OWN_I.
  - both asserted: fixed priority, D wins (see Optional Feature).
  - Grant latency: req sampled at edge N, grant visible in cycle N+1.
- OWN_x: stay while xreq_i=1.
- When xreq_i=0 at an edge:
  - other master requesting -> OWN_other directly, with no idle cycle.
  - otherwise -> IDLE.
- Release uses only req. A master must keep req high until its final ack has been received. A master that drops req with cyc still high is a protocol error; the arbiter still releases.
- Bus outputs are combinational mux by state:
  - OWN_I: wbm* = i*_i.
  - OWN_D: wbm* = d*_i.
  - IDLE: wbmadr_o, wbmdat_o, wbmwe_o, wbmstb_o, wbmcyc_o, wbmsel_o all 0.
- Ack routing: iack_o = wbmack_i & (state==OWN_I); dack_o = wbmack_i & (state==OWN_D). A stray ack in IDLE is dropped.
- Read data: idat_o = ddat_o = wbmdat_i (broadcast). Masters qualify it with their own ack.
- A non-granted master's cyc/stb is ignored and never reaches the bus.
- Requests are ignored in the same cycle reset_i is high.
- Starvation: with fixed priority, a continuously requesting D-master can starve I. This is acceptable; the LSU drops req between instructions.

Optional Feature:
- Macro: WB_ARBITER_ROUND_ROBIN_EN.
- Defined: adds a 1-bit last-owner register, reset to I.
  - Updated on every entry to OWN_I or OWN_D.
  - On simultaneous requests (in IDLE, or at handoff), the master that was NOT last owner wins.
- Undefined: fixed D-over-I priority and no extra register.

Test Plan:
- Reset, no requests: all wbm* = 0, igrant_o = dgrant_o = 0, and this holds for 10 cycles.
- ireq_i=1 at edge 0 -> igrant_o=1 from cycle 1.
  - iadr_i=0x1000, istb_i=icyc_i=1 -> wbmadr_o=0x1000.
  - wbmack_i=1, wbmdat_i=0xBEEF -> iack_o=1, idat_o=0xBEEF, dack_o=0.
- ireq_i and dreq_i both rise at the same edge:
  - Fixed priority: dgrant_o=1 next cycle. D drops req -> igrant_o=1 the following cycle, no IDLE gap.
  - Round-robin build, after reset: D first, then I; repeating the request pair grants D then I again.
- D owns bus doing a 4-beat dword access, ireq_i asserted throughout -> all 4 acks go to dack_o only; wbmadr_o tracks dadr_i; I granted only after dreq_i falls.
- wbmack_i=1 pulsed while IDLE -> iack_o = dack_o = 0, state stays IDLE.
- reset_i asserted mid-transfer while OWN_D with wbmcyc_o=1 -> next cycle wbmcyc_o=0, dgrant_o=0, state IDLE.

Source files
------------

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Two-master to one-slave Wishbone B.4 arbiter. The instruction-fetch unit
// (I-master) and the load/store unit (D-master) share the core's single
// external Wishbone master port. A master raises req, waits for its registered
// grant, then drives cyc/stb. It keeps req high until its last ack arrives, so
// a multi-beat transaction is never split.
//
// Optional feature macro: WB_ARBITER_ROUND_ROBIN_EN
//   undefined : fixed priority, D-master wins simultaneous requests
//   defined   : a 1-bit last-owner register is added. When both masters
//               request at once, the master that did not own the bus last
//               wins. After reset the last owner is I, so D goes first.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   ireq_i / igrant_o       I-master request and registered grant
//   iadr_i..isel_i          I-master bus signals (address, data, we, stb, cyc, sel)
//   iack_o, idat_o          ack and read data returned to the I-master
//   dreq_i .. ddat_o        same set of signals for the D-master
//   wbmadr_o..wbmsel_o      shared bus outputs (zero while no master owns the bus)
//   wbmack_i, wbmdat_i      shared bus ack and read data
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int AW = 64,
   parameter int DW = 16,
   parameter int SW = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   // I-master
   input  logic          ireq_i,
   output logic          igrant_o,
   input  logic [AW-1:0] iadr_i,
   input  logic [DW-1:0] idat_i,
   input  logic          iwe_i,
   input  logic          istb_i,
   input  logic          icyc_i,
   input  logic [SW-1:0] isel_i,
   output logic          iack_o,
   output logic [DW-1:0] idat_o,
   // D-master
   input  logic          dreq_i,
   output logic          dgrant_o,
   input  logic [AW-1:0] dadr_i,
   input  logic [DW-1:0] ddat_i,
   input  logic          dwe_i,
   input  logic          dstb_i,
   input  logic          dcyc_i,
   input  logic [SW-1:0] dsel_i,
   output logic          dack_o,
   output logic [DW-1:0] ddat_o,
   // shared bus
   output logic [AW-1:0] wbmadr_o,
   output logic [DW-1:0] wbmdat_o,
   output logic          wbmwe_o,
   output logic          wbmstb_o,
   output logic          wbmcyc_o,
   output logic [SW-1:0] wbmsel_o,
   input  logic          wbmack_i,
   input  logic [DW-1:0] wbmdat_i
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_I = 2'd1;
   localparam logic [1:0] OWN_D = 2'd2;

   logic [1:0] state_r;
   logic [1:0] state_next_s;
   logic       pick_d_s;      // winner when both masters request together

`ifdef WB_ARBITER_ROUND_ROBIN_EN
   logic       last_d_r;      // 1: D-master was the most recent owner

   // Tie-break: favour the master that did not own the bus last.
   always_comb begin
      pick_d_s = ~last_d_r;
   end

   // Track the most recent owner on every entry into an owned state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_d_r <= 1'b0;
      end else if ((state_next_s == OWN_D) && (state_r != OWN_D)) begin
         last_d_r <= 1'b1;
      end else if ((state_next_s == OWN_I) && (state_r != OWN_I)) begin
         last_d_r <= 1'b0;
      end else begin
         last_d_r <= last_d_r;
      end
   end
`else
   // Tie-break: the load/store unit always wins.
   always_comb begin
      pick_d_s = 1'b1;
   end
`endif

   // Next-state logic. The owner keeps the bus while its req stays high; on
   // release the bus passes straight to a waiting master without an idle cycle.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (dreq_i && ireq_i) begin
               state_next_s = pick_d_s ? OWN_D : OWN_I;
            end else if (dreq_i) begin
               state_next_s = OWN_D;
            end else if (ireq_i) begin
               state_next_s = OWN_I;
            end else begin
               state_next_s = IDLE;
            end
         end
         OWN_I: begin
            if (ireq_i) begin
               state_next_s = OWN_I;
            end else if (dreq_i) begin
               state_next_s = OWN_D;
            end else begin
               state_next_s = IDLE;
            end
         end
         OWN_D: begin
            if (dreq_i) begin
               state_next_s = OWN_D;
            end else if (ireq_i) begin
               state_next_s = OWN_I;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register. Reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Grants come straight from the state register, so they are registered.
   assign igrant_o = (state_r == OWN_I);
   assign dgrant_o = (state_r == OWN_D);

   // Bus mux by owner. The non-owner's cyc/stb never reach the bus, and the
   // bus is fully quiet while idle.
   always_comb begin
      wbmadr_o = {AW{1'b0}};
      wbmdat_o = {DW{1'b0}};
      wbmwe_o  = 1'b0;
      wbmstb_o = 1'b0;
      wbmcyc_o = 1'b0;
      wbmsel_o = {SW{1'b0}};
      case (state_r)
         OWN_I: begin
            wbmadr_o = iadr_i;
            wbmdat_o = idat_i;
            wbmwe_o  = iwe_i;
            wbmstb_o = istb_i;
            wbmcyc_o = icyc_i;
            wbmsel_o = isel_i;
         end
         OWN_D: begin
            wbmadr_o = dadr_i;
            wbmdat_o = ddat_i;
            wbmwe_o  = dwe_i;
            wbmstb_o = dstb_i;
            wbmcyc_o = dcyc_i;
            wbmsel_o = dsel_i;
         end
         default: begin
            wbmadr_o = {AW{1'b0}};
            wbmdat_o = {DW{1'b0}};
            wbmwe_o  = 1'b0;
            wbmstb_o = 1'b0;
            wbmcyc_o = 1'b0;
            wbmsel_o = {SW{1'b0}};
         end
      endcase
   end

   // Ack goes only to the owner; a stray ack while idle is dropped.
   assign iack_o = wbmack_i & (state_r == OWN_I);
   assign dack_o = wbmack_i & (state_r == OWN_D);

   // Read data is broadcast; each master qualifies it with its own ack.
   assign idat_o = wbmdat_i;
   assign ddat_o = wbmdat_i;

endmodule
